bulk_in_mux: RTL and testbench

N-channel bulk IN source multiplexer feeding the transactor's bulk IN data path. It generalises the fixed 2:1 telemetry/bulk selector to CHANNELS sources, each bound to a configurable endpoint number. It latches the selection per transaction and never switches mid-packet. It also enforces the max-packet size by inserting tlast and provides a per-endpoint IN-ready status.

---
 rtl/bulk_in_mux.sv | 179 +++++++++++++++++
 tb/tb_bulk_in_mux.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bulk_in_mux.sv
// N-channel bulk IN source selector: binds each source stream to an endpoint number,
// latches the selection per transaction, enforces max-packet size and reports IN-ready.
module bulk_in_mux #(
    parameter int                    CHANNELS   = 2,
    parameter logic [4*CHANNELS-1:0] ENDPOINTS  = {4'd2, 4'd1},
    parameter int                    WIDTH      = 8,
    parameter int                    MAX_PACKET = 512
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      blk_start_i,
    input  logic                      blk_cycle_i,
    input  logic [3:0]                blk_endpt_i,
    output logic                      blk_error_o,
    output logic                      blk_in_ready_o,
    input  logic [CHANNELS-1:0]       ch_ready_i,
    output logic [CHANNELS-1:0]       sel_o,
    input  logic [CHANNELS-1:0]       s_tvalid,
    output logic [CHANNELS-1:0]       s_tready,
    input  logic [CHANNELS-1:0]       s_tlast,
    input  logic [WIDTH*CHANNELS-1:0] s_tdata,
    output logic                      m_tvalid,
    input  logic                      m_tready,
    output logic                      m_tlast,
    output logic [WIDTH-1:0]          m_tdata
);

    localparam int CW = $clog2(MAX_PACKET + 1);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        HOLD,
        DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [CHANNELS-1:0] r_sel;
    logic [CW-1:0]       r_count;
    logic                r_error;
    logic                r_in_ready;

    logic                r_out_valid;
    logic                r_out_last;
    logic [WIDTH-1:0]    r_out_data;
    logic                r_skid_valid;
    logic                r_skid_last;
    logic [WIDTH-1:0]    r_skid_data;

    logic [CHANNELS-1:0] w_match;
    logic [CHANNELS-1:0] w_first;
    logic                w_any_match;
    logic                w_start_ok;
    logic                w_start_bad;
    logic                w_sel_valid;
    logic                w_sel_last;
    logic [WIDTH-1:0]    w_sel_data;
    logic                w_ready_sel;
    logic                w_push;
    logic                w_at_max;
    logic                w_push_last;
    logic                w_drained;
    logic                w_abort;

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            w_match[i] = (ENDPOINTS[4*i +: 4] == blk_endpt_i);
        end
    end

    // Two's-complement trick isolates the lowest set bit, so the lowest channel wins.
    assign w_first     = w_match & (-w_match);
    assign w_any_match = |w_match;
    assign w_start_ok  = (r_state == IDLE) && blk_start_i && w_any_match;
    assign w_start_bad = (r_state == IDLE) && blk_start_i && !w_any_match;

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (r_sel[i]) begin
                w_sel_valid = s_tvalid[i];
                w_sel_last  = s_tlast[i];
                w_sel_data  = s_tdata[WIDTH*i +: WIDTH];
            end
        end
    end

    // Ready depends only on registered state and blk_cycle_i, never on m_tready.
    assign w_ready_sel = (r_state == XFER) && blk_cycle_i && !r_skid_valid;
    assign s_tready    = r_sel & {CHANNELS{w_ready_sel}};
    assign w_push      = w_ready_sel && w_sel_valid;
    assign w_at_max    = (r_count == CW'(MAX_PACKET - 1));
    assign w_push_last = w_sel_last || w_at_max;
    assign w_drained   = !r_out_valid && !r_skid_valid;
    assign w_abort     = (r_state == XFER) && !blk_cycle_i;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_start_ok) w_next = XFER;
            end
            XFER: begin
                if (!blk_cycle_i)              w_next = IDLE;
                else if (w_push && w_sel_last) w_next = DONE;
                else if (w_push && w_at_max)   w_next = HOLD;
            end
            HOLD, DONE: begin
                if (w_drained && !blk_cycle_i) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_sel      <= '0;
            r_count    <= '0;
            r_error    <= 1'b0;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_error    <= w_start_bad;
            r_in_ready <= |(w_match & ch_ready_i);
            if (w_start_ok) begin
                r_sel   <= w_first;
                r_count <= '0;
            end else begin
                if (w_next == IDLE) r_sel <= '0;
                if (w_push && (r_count != CW'(MAX_PACKET))) r_count <= r_count + 1'b1;
            end
        end
    end

    // Output register plus one skid entry; the skid only fills when the output is stalled.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_out_data   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_last  <= 1'b0;
            r_skid_data  <= '0;
        end else if (w_abort) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (!r_out_valid || m_tready) begin
            if (r_skid_valid) begin
                r_out_valid  <= 1'b1;
                r_out_last   <= r_skid_last;
                r_out_data   <= r_skid_data;
                r_skid_valid <= 1'b0;
            end else begin
                r_out_valid <= w_push;
                if (w_push) begin
                    r_out_last <= w_push_last;
                    r_out_data <= w_sel_data;
                end
            end
        end else if (w_push) begin
            r_skid_valid <= 1'b1;
            r_skid_last  <= w_push_last;
            r_skid_data  <= w_sel_data;
        end
    end

    assign sel_o          = r_sel;
    assign blk_error_o    = r_error;
    assign blk_in_ready_o = r_in_ready;
    assign m_tvalid       = r_out_valid;
    assign m_tlast        = r_out_last;
    assign m_tdata        = r_out_data;

endmodule

// File: tb/tb_bulk_in_mux.sv
// Scoreboard bench for bulk_in_mux: dut0 uses default parameters, dut1 uses MAX_PACKET=4;
// 'act' routes the shared stimulus to one of them at a time.
module tb_bulk_in_mux;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        rstN;
    logic        blkStart, blkCycle;
    logic [3:0]  blkEndpt;
    logic [1:0]  chReady;
    logic [1:0]  sValid, sLast;
    logic [15:0] sData;
    logic        mReady;
    logic        act;

    logic        err0, inRdy0, mValid0, mLast0;
    logic [1:0]  sel0, sReady0;
    logic [7:0]  mData0;
    logic        err1, inRdy1, mValid1, mLast1;
    logic [1:0]  sel1, sReady1;
    logic [7:0]  mData1;

    logic        err, inRdy, mValid, mLast;
    logic [1:0]  sel, sReady;
    logic [7:0]  mData;

    assign err    = act ? err1    : err0;
    assign inRdy  = act ? inRdy1  : inRdy0;
    assign mValid = act ? mValid1 : mValid0;
    assign mLast  = act ? mLast1  : mLast0;
    assign mData  = act ? mData1  : mData0;
    assign sel    = act ? sel1    : sel0;
    assign sReady = act ? sReady1 : sReady0;

    bulk_in_mux dut0 (
        .clock(clock), .reset(rstN),
        .blk_start_i(blkStart & ~act), .blk_cycle_i(blkCycle & ~act), .blk_endpt_i(blkEndpt),
        .blk_error_o(err0), .blk_in_ready_o(inRdy0), .ch_ready_i(chReady), .sel_o(sel0),
        .s_tvalid(act ? 2'b00 : sValid), .s_tready(sReady0), .s_tlast(sLast), .s_tdata(sData),
        .m_tvalid(mValid0), .m_tready(mReady), .m_tlast(mLast0), .m_tdata(mData0)
    );

    bulk_in_mux #(.MAX_PACKET(4)) dut1 (
        .clock(clock), .reset(rstN),
        .blk_start_i(blkStart & act), .blk_cycle_i(blkCycle & act), .blk_endpt_i(blkEndpt),
        .blk_error_o(err1), .blk_in_ready_o(inRdy1), .ch_ready_i(chReady), .sel_o(sel1),
        .s_tvalid(act ? sValid : 2'b00), .s_tready(sReady1), .s_tlast(sLast), .s_tdata(sData),
        .m_tvalid(mValid1), .m_tready(mReady), .m_tlast(mLast1), .m_tdata(mData1)
    );

    int errors = 0;
    int checks = 0;
    logic [8:0] expQ[$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: every completed output handshake is compared against the next expected beat,
    // and a stalled beat must be held unchanged.
    logic       prevStall = 1'b0;
    logic [8:0] prevBeat  = '0;
    always @(negedge clock) begin
        if (rstN) begin
            if (prevStall && mValid) checkOutput("stallStable", {mLast, mData}, prevBeat);
            if (mValid && mReady) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedBeat: got 0x%0h expected none", {mLast, mData});
                end else begin
                    checkOutput("beat", {mLast, mData}, expQ.pop_front());
                end
            end
            prevStall = mValid && !mReady;
            prevBeat  = {mLast, mData};
        end
    end

    task automatic applyStimulus(input logic dutSel, input logic [3:0] endpt);
        act      = dutSel;
        blkEndpt = endpt;
        blkCycle = 1'b1;
        blkStart = 1'b1;
        @(posedge clock);
        #1 blkStart = 1'b0;
    endtask

    // readyMode: 0 = m_tready high, 1 = toggling, 2 = held low.
    task automatic runXfer(input int ch, input logic [7:0] base, input int startIdx, input int total,
                           input int readyMode, input bit chkLat, input int cycles, output int idx);
        bit         acc, prevAcc;
        logic [7:0] curByte, prevByte;
        idx      = startIdx;
        prevAcc  = 1'b0;
        prevByte = '0;
        for (int c = 0; c < cycles; c++) begin
            mReady  = (readyMode == 0) ? 1'b1 : (readyMode == 1) ? c[0] : 1'b0;
            sValid  = '0;
            sLast   = '0;
            curByte = base + 8'(idx);
            if (idx < total) begin
                sValid[ch]         = 1'b1;
                sData[8*ch +: 8]   = curByte;
                sLast[ch]          = (idx == total - 1);
            end
            @(negedge clock);
            if (chkLat && prevAcc) checkOutput("latency", {mValid, mData}, {1'b1, prevByte});
            checkOutput("otherReady", 32'(sReady[1-ch]), 32'd0);
            acc = sValid[ch] && sReady[ch];
            @(posedge clock);
            #1;
            prevAcc  = acc;
            prevByte = curByte;
            if (acc) idx++;
        end
        sValid = '0;
        sLast  = '0;
    endtask

    task automatic endXfer();
        blkCycle = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (sel == 2'b00) break;
        end
        checkOutput("returnIdle", 32'(sel), 32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int idx;
        int errCycles;
        logic mvSeen;

        rstN = 1'b0; blkStart = 1'b0; blkCycle = 1'b0; blkEndpt = '0; chReady = '0;
        sValid = '0; sLast = '0; sData = '0; mReady = 1'b1; act = 1'b0;

        #12;
        checkOutput("rstSel",   {sel1, sel0}, 32'd0);
        checkOutput("rstMOut",  {mValid1, mLast1, mData1, mValid0, mLast0, mData0}, 32'd0);
        checkOutput("rstMisc",  {err1, inRdy1, sReady1, err0, inRdy0, sReady0}, 32'd0);
        #4 rstN = 1'b1;

        $display("[TB] endpoint 1, ch0, five bytes with tlast");
        chReady = 2'b01;
        for (int i = 0; i < 5; i++) expQ.push_back({(i == 4), 8'h10 + 8'(i)});
        applyStimulus(1'b0, 4'd1);
        #2 checkOutput("T1 sel", 32'(sel), 32'd1);
        checkOutput("T1 inReady", 32'(inRdy), 32'd1);
        runXfer(0, 8'h10, 0, 5, 0, 1'b1, 10, idx);
        checkOutput("T1 accepted", idx, 5);
        checkOutput("T1 drained", expQ.size(), 0);
        endXfer();

        $display("[TB] MAX_PACKET=4, ch1 offers six bytes across two transactions");
        for (int i = 0; i < 4; i++) expQ.push_back({(i == 3), 8'h20 + 8'(i)});
        applyStimulus(1'b1, 4'd2);
        #2 checkOutput("T2 sel", 32'(sel), 32'd2);
        runXfer(1, 8'h20, 0, 6, 0, 1'b1, 12, idx);
        checkOutput("T2 acceptedFirst", idx, 4);
        checkOutput("T2 holdReady", 32'(sReady), 32'd0);
        checkOutput("T2 drainedFirst", expQ.size(), 0);
        endXfer();
        expQ.push_back({1'b0, 8'h24});
        expQ.push_back({1'b1, 8'h25});
        applyStimulus(1'b1, 4'd2);
        runXfer(1, 8'h20, 4, 6, 0, 1'b1, 8, idx);
        checkOutput("T2 acceptedSecond", idx, 6);
        checkOutput("T2 drainedSecond", expQ.size(), 0);
        endXfer();

        $display("[TB] start to unmapped endpoint 3");
        chReady = 2'b11;
        applyStimulus(1'b0, 4'd3);
        blkCycle  = 1'b0;
        errCycles = 0;
        mvSeen    = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            errCycles += int'(err);
            mvSeen    |= mValid;
        end
        checkOutput("T3 errorCycles", errCycles, 1);
        checkOutput("T3 sel", 32'(sel), 32'd0);
        checkOutput("T3 noValid", 32'(mvSeen), 32'd0);
        checkOutput("T3 inReady", 32'(inRdy), 32'd0);

        $display("[TB] eight bytes with m_tready toggling");
        chReady = 2'b10;
        for (int i = 0; i < 8; i++) expQ.push_back({(i == 7), 8'h30 + 8'(i)});
        applyStimulus(1'b0, 4'd2);
        #2 checkOutput("T4 sel", 32'(sel), 32'd2);
        runXfer(1, 8'h30, 0, 8, 1, 1'b0, 30, idx);
        checkOutput("T4 accepted", idx, 8);
        checkOutput("T4 drained", expQ.size(), 0);
        mReady = 1'b1;
        endXfer();

        $display("[TB] abort after two bytes, then immediate restart");
        applyStimulus(1'b0, 4'd1);
        runXfer(0, 8'h40, 0, 6, 2, 1'b0, 6, idx);
        checkOutput("T5 accepted", idx, 2);
        #1 checkOutput("T5 stalledValid", 32'(mValid), 32'd1);
        blkCycle = 1'b0;
        @(posedge clock);
        #2;
        checkOutput("T5 flushed", 32'(mValid), 32'd0);
        checkOutput("T5 idleSel", 32'(sel), 32'd0);
        mReady = 1'b1;
        for (int i = 0; i < 3; i++) expQ.push_back({(i == 2), 8'h50 + 8'(i)});
        applyStimulus(1'b0, 4'd2);
        #2 checkOutput("T5 restartSel", 32'(sel), 32'd2);
        runXfer(1, 8'h50, 0, 3, 0, 1'b1, 8, idx);
        checkOutput("T5 restartAccepted", idx, 3);
        checkOutput("T5 drained", expQ.size(), 0);
        endXfer();

        $display("[TB] reset asserted mid-transfer");
        chReady = 2'b01;
        applyStimulus(1'b0, 4'd1);
        runXfer(0, 8'h60, 0, 3, 2, 1'b0, 4, idx);
        #1 checkOutput("T6 busy", {mValid, inRdy, sel}, {1'b1, 1'b1, 2'b01});
        @(negedge clock);
        #2 rstN = 1'b0;
        #1;
        checkOutput("T6 rstMOut", {mValid, mLast, mData}, 32'd0);
        checkOutput("T6 rstSel", 32'(sel), 32'd0);
        checkOutput("T6 rstMisc", {err, inRdy, sReady}, 32'd0);
        blkCycle = 1'b0;
        chReady  = 2'b10;
        blkEndpt = 4'd2;
        @(posedge clock);
        #1 rstN = 1'b1;
        @(negedge clock);
        checkOutput("T6 inReadyBefore", 32'(inRdy), 32'd0);
        @(negedge clock);
        checkOutput("T6 inReadyAfter", 32'(inRdy), 32'd1);
        checkOutput("T6 queueEmpty", expQ.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
